seg_frame_decoder: RTL and testbench

SEG_FRAME_DECODER -- requirements
Module: seg_frame_decoder

---
 rtl/seg_frame_decoder_if.sv | 10 +
 rtl/seg_frame_decoder.sv | 161 ++++++++++++++++
 tb/tb_seg_frame_decoder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/seg_frame_decoder_if.sv
// Multiplexed seven-segment scan bus: one-hot digit-pair select plus the
// ones/tens segment patterns for the selected pair.
interface seg_frame_decoder_if;
  logic [3:0] wei;
  logic [7:0] duan;
  logic [7:0] duan1;

  modport master (output wei, output duan, output duan1);
  modport slave  (input  wei, input  duan, input  duan1);
endinterface

// File: rtl/seg_frame_decoder.sv
// Recovers hh:mm:ss.cc from a scanned seven-segment display bus, checking
// pair order and segment content before committing a whole frame.
module seg_frame_decoder (
  input  logic                 clk_scan,
  input  logic                 rst,
  seg_frame_decoder_if.slave   scan,
  output logic [7:0]           hours,
  output logic [7:0]           minutes,
  output logic [7:0]           seconds,
  output logic [7:0]           centisec,
  output logic                 frame_valid,
  output logic                 locked,
  output logic                 seq_err,
  output logic                 seg_err,
  output logic [7:0]           err_count
);

  typedef enum logic [1:0] {HUNT, EXP1, EXP2, EXP3} state_t;

  localparam logic [3:0] W_CS  = 4'b0001;
  localparam logic [3:0] W_SEC = 4'b0010;
  localparam logic [3:0] W_MIN = 4'b0100;
  localparam logic [3:0] W_HR  = 4'b1000;

  // Returns {valid, digit}; the dash and every unlisted pattern are invalid.
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    case (pat)
      7'h7E:   return {1'b1, 4'd0};
      7'h30:   return {1'b1, 4'd1};
      7'h6D:   return {1'b1, 4'd2};
      7'h79:   return {1'b1, 4'd3};
      7'h33:   return {1'b1, 4'd4};
      7'h5B:   return {1'b1, 4'd5};
      7'h5F:   return {1'b1, 4'd6};
      7'h70:   return {1'b1, 4'd7};
      7'h7F:   return {1'b1, 4'd8};
      7'h7B:   return {1'b1, 4'd9};
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  state_t     state, state_nxt;
  logic       bad, bad_nxt;
  logic [7:0] cs_sh, sec_sh, min_sh;
  logic       cap_cs, cap_sec, cap_min, commit;
  logic       seq_err_nxt, seg_err_nxt;

  // ---- stage p0: combinational decode of the currently selected pair ----
  logic [4:0] ones_p0, tens_p0;
  logic       pair_ok_p0, range_ok_p0;
  logic [7:0] pair_val_p0;

  assign ones_p0     = seg_decode(scan.duan[6:0]);
  assign tens_p0     = seg_decode(scan.duan1[6:0]);
  // The separator dot is only legal on the tens digit, and it must be lit.
  assign pair_ok_p0  = ones_p0[4] & tens_p0[4] & ~scan.duan[7] & scan.duan1[7];
  assign pair_val_p0 = ({4'd0, tens_p0[3:0]} * 8'd10) + {4'd0, ones_p0[3:0]};
  assign range_ok_p0 = (pair_val_p0 <= 8'd59);

  always_ff @(posedge clk_scan or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bad_nxt     = bad;
    cap_cs      = 1'b0;
    cap_sec     = 1'b0;
    cap_min     = 1'b0;
    commit      = 1'b0;
    seq_err_nxt = 1'b0;
    seg_err_nxt = 1'b0;
    if (scan.wei == 4'b0000) begin
      state_nxt = state;
    end else if (!$onehot(scan.wei)) begin
      seq_err_nxt = 1'b1;
      state_nxt   = HUNT;
    end else if (scan.wei == W_CS) begin
      // A fresh start mid-frame is both an order error and a new frame.
      seq_err_nxt = (state != HUNT);
      bad_nxt     = ~pair_ok_p0;
      cap_cs      = 1'b1;
      state_nxt   = EXP1;
    end else begin
      case (state)
        HUNT: state_nxt = HUNT;
        EXP1: begin
          if (scan.wei == W_SEC) begin
            cap_sec   = 1'b1;
            bad_nxt   = bad | ~pair_ok_p0 | ~range_ok_p0;
            state_nxt = EXP2;
          end else begin
            seq_err_nxt = 1'b1;
            state_nxt   = HUNT;
          end
        end
        EXP2: begin
          if (scan.wei == W_MIN) begin
            cap_min   = 1'b1;
            bad_nxt   = bad | ~pair_ok_p0 | ~range_ok_p0;
            state_nxt = EXP3;
          end else begin
            seq_err_nxt = 1'b1;
            state_nxt   = HUNT;
          end
        end
        default: begin
          if (scan.wei == W_HR) begin
            if (bad || !pair_ok_p0) seg_err_nxt = 1'b1;
            else                    commit      = 1'b1;
          end else begin
            seq_err_nxt = 1'b1;
          end
          state_nxt = HUNT;
        end
      endcase
    end
  end

  // ---- stage p1: shadow capture, commit and status registers ----
  always_ff @(posedge clk_scan or posedge rst) begin
    if (rst) begin
      bad         <= 1'b0;
      cs_sh       <= 8'd0;
      sec_sh      <= 8'd0;
      min_sh      <= 8'd0;
      hours       <= 8'd0;
      minutes     <= 8'd0;
      seconds     <= 8'd0;
      centisec    <= 8'd0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
      seq_err     <= 1'b0;
      seg_err     <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      bad         <= bad_nxt;
      frame_valid <= commit;
      seq_err     <= seq_err_nxt;
      seg_err     <= seg_err_nxt;
      if (cap_cs)  cs_sh  <= pair_val_p0;
      if (cap_sec) sec_sh <= pair_val_p0;
      if (cap_min) min_sh <= pair_val_p0;
      if (commit) begin
        hours    <= pair_val_p0;
        minutes  <= min_sh;
        seconds  <= sec_sh;
        centisec <= cs_sh;
      end
      if (seq_err_nxt) locked <= 1'b0;
      else if (commit) locked <= 1'b1;
      if (seq_err_nxt || seg_err_nxt) err_count <= sat_inc(err_count);
    end
  end

endmodule

// File: tb/tb_seg_frame_decoder.sv
// Directed table-driven bench for seg_frame_decoder plus hand-written
// sequences for start-up, asynchronous reset and error-count saturation.
module tb_seg_frame_decoder;

  logic       clk_scan = 1'b0;
  logic       rst;
  logic [7:0] hours, minutes, seconds, centisec, err_count;
  logic       frame_valid, locked, seq_err, seg_err;

  seg_frame_decoder_if scan ();

  seg_frame_decoder dut (
    .clk_scan    (clk_scan),
    .rst         (rst),
    .scan        (scan),
    .hours       (hours),
    .minutes     (minutes),
    .seconds     (seconds),
    .centisec    (centisec),
    .frame_valid (frame_valid),
    .locked      (locked),
    .seq_err     (seq_err),
    .seg_err     (seg_err),
    .err_count   (err_count)
  );

  always #5 clk_scan = ~clk_scan;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  wei;
    logic [15:0] pat;   // {duan1, duan}
    logic        fv, sq, sg, lk;
    logic [31:0] vals;  // {hours, minutes, seconds, centisec}
    logic [7:0]  ec;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] sp(input int d);
    case (d)
      0: return 8'h7E;  1: return 8'h30;  2: return 8'h6D;  3: return 8'h79;
      4: return 8'h33;  5: return 8'h5B;  6: return 8'h5F;  7: return 8'h70;
      8: return 8'h7F;  default: return 8'h7B;
    endcase
  endfunction

  // Well-formed pair: dot lit on tens, dark on ones.
  function automatic logic [15:0] pr(input int v);
    return {8'h80 | sp(v / 10), sp(v % 10)};
  endfunction

  function automatic logic [31:0] tv(input int h, input int m, input int s, input int c);
    return {8'(h), 8'(m), 8'(s), 8'(c)};
  endfunction

  task automatic add(input logic [3:0] w, input logic [15:0] p, input logic fv, input logic sq,
                     input logic sg, input logic lk, input logic [31:0] v, input logic [7:0] ec);
    vec_t r;
    r.wei = w; r.pat = p; r.fv = fv; r.sq = sq; r.sg = sg; r.lk = lk; r.vals = v; r.ec = ec;
    vecs.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] w, input logic [15:0] p);
    scan.wei = w;
    {scan.duan1, scan.duan} = p;
    @(posedge clk_scan);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic fv, input logic sq, input logic sg,
                         input logic lk, input logic [31:0] v, input logic [7:0] ec);
    chk({tag, " frame_valid"}, 32'(frame_valid), 32'(fv));
    chk({tag, " seq_err"},     32'(seq_err),     32'(sq));
    chk({tag, " seg_err"},     32'(seg_err),     32'(sg));
    chk({tag, " locked"},      32'(locked),      32'(lk));
    chk({tag, " values"},      {hours, minutes, seconds, centisec}, v);
    chk({tag, " err_count"},   32'(err_count),   32'(ec));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    scan.wei = 4'b0000;
    {scan.duan1, scan.duan} = 16'h0000;
    @(posedge clk_scan);
    @(posedge clk_scan);
    #1;
    rst = 1'b0;
  endtask

  localparam logic [31:0] V0 = 32'd0;

  initial begin
    logic [31:0] v1, v2;
    v1 = tv(12, 34, 56, 78);
    v2 = tv(23, 59, 59, 99);

    do_reset();
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, V0, 8'd0);

    // good frame 12:34:56.78
    add(4'b0001, pr(78), 0, 0, 0, 0, V0, 0);
    add(4'b0010, pr(56), 0, 0, 0, 0, V0, 0);
    add(4'b0100, pr(34), 0, 0, 0, 0, V0, 0);
    add(4'b1000, pr(12), 1, 0, 0, 1, v1, 0);
    add(4'b0000, pr(12), 0, 0, 0, 1, v1, 0);
    // dash on seconds ones digit
    add(4'b0001, pr(78),   0, 0, 0, 1, v1, 0);
    add(4'b0010, 16'hDB01, 0, 0, 0, 1, v1, 0);
    add(4'b0100, pr(34),   0, 0, 0, 1, v1, 0);
    add(4'b1000, pr(12),   0, 0, 1, 1, v1, 1);
    // skipped minutes pair
    add(4'b0001, pr(78), 0, 0, 0, 1, v1, 1);
    add(4'b0010, pr(56), 0, 0, 0, 1, v1, 1);
    add(4'b1000, pr(12), 0, 1, 0, 0, v1, 2);
    add(4'b0100, pr(34), 0, 0, 0, 0, v1, 2);
    // minutes = 60
    add(4'b0001, pr(78), 0, 0, 0, 0, v1, 2);
    add(4'b0010, pr(56), 0, 0, 0, 0, v1, 2);
    add(4'b0100, pr(60), 0, 0, 0, 0, v1, 2);
    add(4'b1000, pr(12), 0, 0, 1, 0, v1, 3);
    // idle hold, then non-one-hot select
    add(4'b0001, pr(99), 0, 0, 0, 0, v1, 3);
    add(4'b0000, pr(99), 0, 0, 0, 0, v1, 3);
    add(4'b0011, pr(99), 0, 1, 0, 0, v1, 4);
    // restart from EXP3, then complete 23:59:59.99
    add(4'b0001, pr(99), 0, 0, 0, 0, v1, 4);
    add(4'b0010, pr(59), 0, 0, 0, 0, v1, 4);
    add(4'b0100, pr(59), 0, 0, 0, 0, v1, 4);
    add(4'b0001, pr(99), 0, 1, 0, 0, v1, 5);
    add(4'b0010, pr(59), 0, 0, 0, 0, v1, 5);
    add(4'b0000, pr(59), 0, 0, 0, 0, v1, 5);
    add(4'b0100, pr(59), 0, 0, 0, 0, v1, 5);
    add(4'b1000, pr(23), 1, 0, 0, 1, v2, 5);
    // dot lit on hours ones digit
    add(4'b0001, pr(0),    0, 0, 0, 1, v2, 5);
    add(4'b0010, pr(0),    0, 0, 0, 1, v2, 5);
    add(4'b0100, pr(0),    0, 0, 0, 1, v2, 5);
    add(4'b1000, 16'hB0FE, 0, 0, 1, 1, v2, 6);
    // stray hours select while hunting
    add(4'b1000, pr(11),   0, 0, 0, 1, v2, 6);

    foreach (vecs[i]) begin
      drive(vecs[i].wei, vecs[i].pat);
      chk_all($sformatf("vec%0d", i), vecs[i].fv, vecs[i].sq, vecs[i].sg, vecs[i].lk,
              vecs[i].vals, vecs[i].ec);
    end

    // first select after reset is minutes: silently ignored
    do_reset();
    drive(4'b0100, pr(34));
    chk_all("startup_min", 0, 0, 0, 0, V0, 0);
    drive(4'b1000, pr(12));
    chk_all("startup_hr", 0, 0, 0, 0, V0, 0);
    drive(4'b0001, pr(78));
    drive(4'b0010, pr(56));
    drive(4'b0100, pr(34));
    drive(4'b1000, pr(12));
    chk_all("startup_commit", 1, 0, 0, 1, v1, 0);

    // asynchronous reset after the seconds sample
    drive(4'b0001, pr(99));
    drive(4'b0010, pr(59));
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, V0, 0);
    @(posedge clk_scan);
    #1;
    rst = 1'b0;
    drive(4'b0100, pr(59));
    drive(4'b1000, pr(23));
    chk_all("post_rst_partial", 0, 0, 0, 0, V0, 0);
    drive(4'b0001, pr(99));
    drive(4'b0010, pr(59));
    drive(4'b0100, pr(59));
    drive(4'b1000, pr(23));
    chk_all("post_rst_commit", 1, 0, 0, 1, v2, 0);

    // error counter saturation
    for (int k = 0; k < 300; k++) drive(4'b0110, 16'h0000);
    chk_all("saturate", 0, 1, 0, 0, v2, 8'd255);
    drive(4'b0000, 16'h0000);
    chk_all("saturate_idle", 0, 0, 0, 0, v2, 8'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
